// File: rtl/fetch_stage.sv
// IF stage: issues one-at-a-time IMEM requests, buffers returned words in a small
// prefetch FIFO and drives the IF/ID register, absorbing stalls, flushes and IMEM latency.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        PCWrite_i,
   input  logic        IFIDStall_i,
   input  logic        IFIDFlush_i,
   input  logic [31:0] branch_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] pc_IFID_o,
   output logic [31:0] instr_IFID_o,
   output logic        valid_IFID_o
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

   state_t           r_state;
   logic [31:0]      r_fetch_pc;
   logic [31:0]      r_fifo_pc    [FIFO_DEPTH];
   logic [31:0]      r_fifo_instr [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [31:0]      r_pc_ifid;
   logic [31:0]      r_instr_ifid;
   logic             r_valid_ifid;

   logic             w_hold;
   logic             w_push;
   logic             w_pop;
   logic [CNT_W-1:0] w_count_next;
   logic [31:0]      w_branch_pc;

   assign w_hold      = IFIDStall_i | ~PCWrite_i;
   assign w_branch_pc = {branch_pc_i[31:2], 2'b00};
   // A flush discards both the returning word and the FIFO contents, so it masks push and pop.
   assign w_push      = (r_state == S_REQ) && imem_ack_i && !IFIDFlush_i;
   assign w_pop       = !IFIDFlush_i && !w_hold && (r_count != '0);

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop)
         w_count_next = r_count + CNT_W'(1);
      else if (!w_push && w_pop)
         w_count_next = r_count - CNT_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= RESET_PC;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (IFIDFlush_i)
                  r_fetch_pc <= w_branch_pc;
               else if (r_count < DEPTH_C)
                  r_state <= S_REQ;
            end
            S_REQ: begin
               if (IFIDFlush_i) begin
                  r_fetch_pc <= w_branch_pc;
                  r_state    <= imem_ack_i ? S_REQ : S_DROP;
               end else if (imem_ack_i) begin
                  r_fetch_pc <= r_fetch_pc + 32'd4;
                  r_state    <= (w_count_next < DEPTH_C) ? S_REQ : S_IDLE;
               end
            end
            S_DROP: begin
               if (IFIDFlush_i)
                  r_fetch_pc <= w_branch_pc;
               if (imem_ack_i)
                  r_state <= S_REQ;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_pc_ifid    <= '0;
         r_instr_ifid <= NOP_INSTR;
         r_valid_ifid <= 1'b0;
      end else if (IFIDFlush_i) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_pc_ifid    <= '0;
         r_instr_ifid <= NOP_INSTR;
         r_valid_ifid <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         r_count <= w_count_next;
         if (w_pop) begin
            r_rd_ptr     <= r_rd_ptr + PTR_W'(1);
            r_pc_ifid    <= r_fifo_pc[r_rd_ptr];
            r_instr_ifid <= r_fifo_instr[r_rd_ptr];
            r_valid_ifid <= 1'b1;
         end else if (!w_hold) begin
            r_pc_ifid    <= '0;
            r_instr_ifid <= NOP_INSTR;
            r_valid_ifid <= 1'b0;
         end
      end
   end

   // NOTE: FIFO storage is not reset; the count and pointers alone decide what is valid.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo_pc[r_wr_ptr]    <= r_fetch_pc;
         r_fifo_instr[r_wr_ptr] <= imem_rdata_i;
      end
   end

   assign imem_req_o   = (r_state != S_IDLE);
   assign imem_addr_o  = r_fetch_pc;
   assign pc_IFID_o    = r_pc_ifid;
   assign instr_IFID_o = r_instr_ifid;
   assign valid_IFID_o = r_valid_ifid;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: an in-bench IMEM responder with selectable latency
// plus hand-driven acks for the flush and reset scenarios.
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_write;
   logic        stall;
   logic        flush;
   logic [31:0] branch_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc_ifid;
   logic [31:0] instr_ifid;
   logic        valid_ifid;

   int total = 0;
   int bad = 0;
   bit auto_mode;
   int lat;
   int wait_cnt;

   fetch_stage dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .PCWrite_i    (pc_write),
      .IFIDStall_i  (stall),
      .IFIDFlush_i  (flush),
      .branch_pc_i  (branch_pc),
      .imem_req_o   (imem_req),
      .imem_addr_o  (imem_addr),
      .imem_ack_i   (imem_ack),
      .imem_rdata_i (imem_rdata),
      .pc_IFID_o    (pc_ifid),
      .instr_IFID_o (instr_ifid),
      .valid_IFID_o (valid_ifid)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic v);
      check({tag, "_pc"}, pc_ifid, pc);
      check({tag, "_instr"}, instr_ifid, ins);
      check({tag, "_valid"}, 32'(valid_ifid), 32'(v));
   endtask

   task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
      check({tag, "_req"}, 32'(imem_req), 32'(r));
      if (r) check({tag, "_addr"}, imem_addr, a);
   endtask

   // Advance to the next falling edge; in auto mode answer the request after `lat` cycles.
   task automatic tick();
      @(negedge clk);
      if (auto_mode) begin
         imem_ack = 1'b0;
         if (imem_req) begin
            wait_cnt++;
            if (wait_cnt >= lat) begin
               imem_ack   = 1'b1;
               imem_rdata = word(imem_addr);
               wait_cnt   = 0;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   endtask

   initial begin
      rst = 1'b1; pc_write = 1'b1; stall = 1'b0; flush = 1'b0; branch_pc = '0;
      imem_ack = 1'b0; imem_rdata = '0; auto_mode = 1'b0; lat = 1; wait_cnt = 0;
      tick(); tick();
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      chk_ifid("rst", 32'h0, NOP, 1'b0);
      rst = 1'b0; auto_mode = 1'b1;

      // single-cycle IMEM: streaming
      tick(); chk_req("t1_first", 1'b1, 32'h0); check("t1_b0", 32'(valid_ifid), 32'd0);
      tick(); check("t1_b1", 32'(valid_ifid), 32'd0);
      tick(); chk_ifid("t1_i0", 32'h0, word(32'h0), 1'b1);
      tick(); chk_ifid("t1_i1", 32'h4, word(32'h4), 1'b1);
      tick(); chk_ifid("t1_i2", 32'h8, word(32'h8), 1'b1);

      // stall/hold for four edges
      stall = 1'b1; pc_write = 1'b0;
      tick(); chk_ifid("t3_h0", 32'h8, word(32'h8), 1'b1);
      tick(); check("t3_req_drop", 32'(imem_req), 32'd0);
      tick();
      tick(); chk_ifid("t3_h3", 32'h8, word(32'h8), 1'b1); check("t3_req_off", 32'(imem_req), 32'd0);
      stall = 1'b0; pc_write = 1'b1;
      tick(); chk_ifid("t3_r0", 32'hC, word(32'hC), 1'b1);
      lat = 3;
      tick(); chk_ifid("t3_r1", 32'h10, word(32'h10), 1'b1); chk_req("t3_refetch", 1'b1, 32'h14);

      // three-cycle IMEM: bubbles, stable address
      tick(); chk_ifid("t2_bub0", 32'h0, NOP, 1'b0); chk_req("t2_w1", 1'b1, 32'h14);
      tick(); chk_req("t2_w2", 1'b1, 32'h14); check("t2_bub1", 32'(valid_ifid), 32'd0);
      tick(); check("t2_bub2", 32'(valid_ifid), 32'd0);
      tick(); chk_ifid("t2_i0", 32'h14, word(32'h14), 1'b1);
      tick(); check("t2_bub3", 32'(valid_ifid), 32'd0);
      tick();
      tick(); chk_ifid("t2_i1", 32'h18, word(32'h18), 1'b1);

      // flush while a request is outstanding
      auto_mode = 1'b0; imem_ack = 1'b0;
      flush = 1'b1; branch_pc = 32'h100;
      tick(); chk_ifid("t4_bub", 32'h0, NOP, 1'b0); check("t4_req_pend", 32'(imem_req), 32'd1);
      flush = 1'b0; imem_ack = 1'b1; imem_rdata = word(32'h1C);
      tick(); check("t4_late_drop", 32'(valid_ifid), 32'd0); chk_req("t4_redir", 1'b1, 32'h100);
      imem_ack = 1'b1; imem_rdata = word(32'h100);
      tick(); imem_ack = 1'b0; check("t4_lat", 32'(valid_ifid), 32'd0);
      tick(); chk_ifid("t4_tgt", 32'h100, word(32'h100), 1'b1); chk_req("t4_next", 1'b1, 32'h104);

      // flush wins over stall
      flush = 1'b1; stall = 1'b1; branch_pc = 32'h200;
      tick(); chk_ifid("t5_fw", 32'h0, NOP, 1'b0);
      flush = 1'b0; stall = 1'b0; imem_ack = 1'b1; imem_rdata = word(32'h104);
      tick(); chk_req("t5_redir", 1'b1, 32'h200);
      // flush coincident with ack, unaligned target
      imem_ack = 1'b1; imem_rdata = word(32'h200); flush = 1'b1; branch_pc = 32'h302;
      tick(); flush = 1'b0; chk_req("t5_ackflush", 1'b1, 32'h300); check("t5_bub", 32'(valid_ifid), 32'd0);
      imem_ack = 1'b1; imem_rdata = word(32'h300);
      tick(); imem_ack = 1'b0; check("t5_nodrop", 32'(valid_ifid), 32'd0);
      tick(); chk_ifid("t5_tgt", 32'h300, word(32'h300), 1'b1);

      // reset mid-request with one FIFO entry
      stall = 1'b1; imem_ack = 1'b1; imem_rdata = word(32'h304);
      tick(); imem_ack = 1'b0; stall = 1'b0;
      chk_ifid("t6_pre", 32'h300, word(32'h300), 1'b1); chk_req("t6_pre", 1'b1, 32'h308);
      #2 rst = 1'b1;
      #1 chk_ifid("t6_async", 32'h0, NOP, 1'b0);
      check("t6_async_req", 32'(imem_req), 32'd0);
      check("t6_async_addr", imem_addr, 32'h0);
      tick(); rst = 1'b0; imem_ack = 1'b1; imem_rdata = word(32'h308);
      tick(); chk_req("t6_restart", 1'b1, 32'h0); check("t6_ign", 32'(valid_ifid), 32'd0);
      imem_ack = 1'b1; imem_rdata = word(32'h0);
      tick(); imem_ack = 1'b0; check("t6_empty", 32'(valid_ifid), 32'd0);
      tick(); chk_ifid("t6_i0", 32'h0, word(32'h0), 1'b1);

      // fetch_pc wraps from 0xFFFF_FFFC to 0
      flush = 1'b1; branch_pc = 32'hFFFF_FFFC;
      tick(); flush = 1'b0; imem_ack = 1'b1; imem_rdata = word(32'h4);
      tick(); chk_req("wrap_top", 1'b1, 32'hFFFF_FFFC);
      imem_ack = 1'b1; imem_rdata = word(32'hFFFF_FFFC);
      tick(); imem_ack = 1'b0; chk_req("wrap_zero", 1'b1, 32'h0);
      tick(); chk_ifid("wrap_out", 32'hFFFF_FFFC, word(32'hFFFF_FFFC), 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
